instr_sequencer: RTL and testbench

- Multicycle sequencer for the CPU datapath; sits between the combinational instruction decoder and the PC, IR, flags, register file and memory interfaces.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Converts the decoder's level outputs into single-cycle write strobes.
- Handles the request/acknowledge handshake to instruction and data memory, with a watchdog timeout.

---
 rtl/instr_sequencer_if.sv | 14 +
 rtl/instr_sequencer.sv | 146 ++++++++++++++
 tb/tb_instr_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Memory handshake bundle between the sequencer and instruction/data memory.
// A request stays high until its ack arrives; the ack is sampled only in the matching request state.
interface instr_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, output dmem_req, output dmem_we,
                  input  imem_ack, input  dmem_ack);
  modport slave  (input  imem_req, input  dmem_req, input  dmem_we,
                  output imem_ack, output dmem_ack);
endinterface

// File: rtl/instr_sequencer.sv
// Multicycle fetch/decode/execute/memory/writeback sequencer with single-cycle
// write strobes and a memory-ack watchdog that parks the core in a sticky error state.
module instr_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [1:0]        dec_op,
  input  logic              dec_cond_pass,
  input  logic              dec_reg_wr,
  input  logic              dec_mem_wr,
  input  logic              dec_alu_set,
  instr_sequencer_if.master mem,
  output logic              ir_en,
  output logic              pc_en,
  output logic              pc_sel_branch,
  output logic              flags_en,
  output logic              rf_we,
  output logic              busy,
  output logic              error,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic               error_q, error_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      error_q <= 1'b0;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    error_d       = error_q;
    cnt_d         = cnt_q;
    wait_d        = '0;
    retire        = 1'b0;
    mem.imem_req  = 1'b0;
    mem.dmem_req  = 1'b0;
    mem.dmem_we   = 1'b0;
    ir_en         = 1'b0;
    pc_en         = 1'b0;
    pc_sel_branch = 1'b0;
    flags_en      = 1'b0;
    rf_we         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ack) begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (!dec_cond_pass || dec_op == 2'd3) retire = 1'b1;
        else                                  state_d = S_EXEC;
      end
      S_EXEC: begin
        flags_en = dec_alu_set && (dec_op == 2'd0);
        case (dec_op)
          2'd0: begin
            if (dec_reg_wr) state_d = S_WB;
            else            retire  = 1'b1;
          end
          2'd1: state_d = S_MEM;
          2'd2: begin
            retire        = 1'b1;
            pc_sel_branch = 1'b1;
          end
          default: retire = 1'b1;
        endcase
      end
      S_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = dec_mem_wr;
        if (mem.dmem_ack) begin
          if (dec_reg_wr) state_d = S_WB;
          else            retire  = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    // Every retirement path funnels through here so pc_en pulses exactly once per instruction.
    if (retire) begin
      pc_en   = 1'b1;
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = run ? S_FETCH : S_IDLE;
    end
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_ERR);
  assign error       = error_q;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle state/strobe checks against hand-derived values.
module tb_instr_sequencer;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 16;

  localparam logic [7:0] S_IREQ = 8'h80;
  localparam logic [7:0] S_DREQ = 8'h40;
  localparam logic [7:0] S_DWE  = 8'h20;
  localparam logic [7:0] S_IR   = 8'h10;
  localparam logic [7:0] S_PC   = 8'h08;
  localparam logic [7:0] S_BR   = 8'h04;
  localparam logic [7:0] S_FL   = 8'h02;
  localparam logic [7:0] S_RF   = 8'h01;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run;
  logic [1:0]       dec_op;
  logic             dec_cond_pass, dec_reg_wr, dec_mem_wr, dec_alu_set;
  logic             ir_en, pc_en, pc_sel_branch, flags_en, rf_we, busy, error;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  instr_sequencer_if mem_if ();

  instr_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .dec_op        (dec_op),
    .dec_cond_pass (dec_cond_pass),
    .dec_reg_wr    (dec_reg_wr),
    .dec_mem_wr    (dec_mem_wr),
    .dec_alu_set   (dec_alu_set),
    .mem           (mem_if),
    .ir_en         (ir_en),
    .pc_en         (pc_en),
    .pc_sel_branch (pc_sel_branch),
    .flags_en      (flags_en),
    .rf_we         (rf_we),
    .busy          (busy),
    .error         (error),
    .state         (state),
    .instr_count   (instr_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {busy, mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_we, ir_en,
            pc_en, pc_sel_branch, flags_en, rf_we};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the current state and strobes, then advance one clock.
  task automatic cyc(input string tag, input logic [2:0] es, input logic [7:0] estr);
    logic eb;
    eb = (es != 3'd0) && (es != 3'd7);
    #1;
    check({tag, "_st"}, 32'(state), 32'(es));
    check({tag, "_out"}, 32'(outs()), 32'({eb, estr}));
    tick();
  endtask

  task automatic set_dec(input logic [1:0] op, input logic cp, input logic rw,
                         input logic mw, input logic as);
    dec_op        = op;
    dec_cond_pass = cp;
    dec_reg_wr    = rw;
    dec_mem_wr    = mw;
    dec_alu_set   = as;
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    set_dec(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", 32'(outs()), 32'd0);
    check("rst_cnt", 32'(instr_count), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    #11 rst_n = 1'b1;
    tick();

    // Data-proc with writeback, imem_ack tied high: 1,2,3,5
    run = 1'b1;
    mem_if.imem_ack = 1'b1;
    set_dec(2'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("dp_idle", 3'd0, 8'h00);
    cyc("dp_f", 3'd1, S_IREQ | S_IR);
    cyc("dp_d", 3'd2, 8'h00);
    cyc("dp_e", 3'd3, S_FL);
    cyc("dp_w", 3'd5, S_RF | S_PC);
    check("dp_cnt", 32'(instr_count), 32'd1);

    // Branch: retires from EXEC with branch target select
    set_dec(2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("br_f", 3'd1, S_IREQ | S_IR);
    cyc("br_d", 3'd2, 8'h00);
    cyc("br_e", 3'd3, S_PC | S_BR);
    check("br_cnt", 32'(instr_count), 32'd2);

    // LDR, dmem_ack arrives in the 4th MEM cycle (last accepted wait cycle)
    set_dec(2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("ldr_f", 3'd1, S_IREQ | S_IR);
    cyc("ldr_d", 3'd2, 8'h00);
    cyc("ldr_e", 3'd3, 8'h00);
    cyc("ldr_m0", 3'd4, S_DREQ);
    cyc("ldr_m1", 3'd4, S_DREQ);
    cyc("ldr_m2", 3'd4, S_DREQ);
    mem_if.dmem_ack = 1'b1;
    cyc("ldr_m3", 3'd4, S_DREQ);
    mem_if.dmem_ack = 1'b0;
    cyc("ldr_w", 3'd5, S_RF | S_PC);
    check("ldr_cnt", 32'(instr_count), 32'd3);

    // STR, both acks high during MEM: only dmem_ack counts
    set_dec(2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    mem_if.dmem_ack = 1'b1;
    cyc("str_f", 3'd1, S_IREQ | S_IR);
    cyc("str_d", 3'd2, 8'h00);
    cyc("str_e", 3'd3, 8'h00);
    cyc("str_m", 3'd4, S_DREQ | S_DWE | S_PC);
    check("str_cnt", 32'(instr_count), 32'd4);

    // Condition fail on a store: retires in DECODE, no memory/flag/rf strobes
    set_dec(2'd1, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("cf_f", 3'd1, S_IREQ | S_IR);
    cyc("cf_d", 3'd2, S_PC);
    check("cf_cnt", 32'(instr_count), 32'd5);

    // NOP
    set_dec(2'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    mem_if.dmem_ack = 1'b0;
    cyc("nop_f", 3'd1, S_IREQ | S_IR);
    cyc("nop_d", 3'd2, S_PC);
    check("nop_cnt", 32'(instr_count), 32'd6);

    // run drops mid-LDR: completes through WB then IDLE
    set_dec(2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("stop_f", 3'd1, S_IREQ | S_IR);
    cyc("stop_d", 3'd2, 8'h00);
    cyc("stop_e", 3'd3, 8'h00);
    cyc("stop_m0", 3'd4, S_DREQ);
    run = 1'b0;
    mem_if.dmem_ack = 1'b1;
    cyc("stop_m1", 3'd4, S_DREQ);
    mem_if.dmem_ack = 1'b0;
    cyc("stop_w", 3'd5, S_RF | S_PC);
    cyc("stop_idle", 3'd0, 8'h00);
    check("stop_cnt", 32'(instr_count), 32'd7);

    // Asynchronous reset during EXEC
    run = 1'b1;
    set_dec(2'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("ar_i", 3'd0, 8'h00);
    cyc("ar_f", 3'd1, S_IREQ | S_IR);
    cyc("ar_d", 3'd2, 8'h00);
    #1 check("ar_exec", 32'(state), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_state", 32'(state), 32'd0);
    check("ar_outs", 32'(outs()), 32'd0);
    check("ar_cnt", 32'(instr_count), 32'd0);
    #2;
    run   = 1'b0;
    rst_n = 1'b1;
    tick();

    // Fetch watchdog: 4 cycles in FETCH without ack, then ERR
    run = 1'b1;
    mem_if.imem_ack = 1'b0;
    cyc("to_i", 3'd0, 8'h00);
    for (int i = 0; i < TIMEOUT; i++) cyc("to_f", 3'd1, S_IREQ);
    #1;
    check("to_state", 32'(state), 32'd7);
    check("to_err", 32'(error), 32'd1);
    check("to_outs", 32'(outs()), 32'd0);
    mem_if.imem_ack = 1'b1;
    tick();
    check("to_hold_state", 32'(state), 32'd7);
    check("to_hold_outs", 32'(outs()), 32'd0);
    mem_if.imem_ack = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("to_rst_state", 32'(state), 32'd0);
    check("to_rst_err", 32'(error), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
